tl_host_aggregator: RTL and testbench

//  Parametrised N-host to 1-device TileLink-UH (A/D channel) aggregator. It merges source-ID

---
 rtl/tl_host_aggregator_if.sv | 46 ++++
 rtl/tl_host_aggregator.sv | 178 +++++++++++++++++
 tb/tb_tl_host_aggregator.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/tl_host_aggregator_if.sv
// TileLink-UH A/D link bundle. Lanes carry per-link A payloads and D valid/ready.
// The D payload is shared by all lanes because the aggregator broadcasts it.
interface tl_host_aggregator_if #(
   parameter int NumLanes    = 1,
   parameter int DataWidth   = 128,
   parameter int AddrWidth   = 56,
   parameter int SourceWidth = 2,
   parameter int SinkWidth   = 1,
   parameter int SizeWidth   = 3
) ();
   logic [NumLanes-1:0]                  a_valid;
   logic [NumLanes-1:0]                  a_ready;
   logic [NumLanes-1:0][2:0]             a_opcode;
   logic [NumLanes-1:0][2:0]             a_param;
   logic [NumLanes-1:0][SizeWidth-1:0]   a_size;
   logic [NumLanes-1:0][SourceWidth-1:0] a_source;
   logic [NumLanes-1:0][AddrWidth-1:0]   a_address;
   logic [NumLanes-1:0][DataWidth/8-1:0] a_mask;
   logic [NumLanes-1:0]                  a_corrupt;
   logic [NumLanes-1:0][DataWidth-1:0]   a_data;

   logic [NumLanes-1:0]                  d_valid;
   logic [NumLanes-1:0]                  d_ready;
   logic [2:0]                           d_opcode;
   logic [1:0]                           d_param;
   logic [SizeWidth-1:0]                 d_size;
   logic [SourceWidth-1:0]               d_source;
   logic [SinkWidth-1:0]                 d_sink;
   logic                                 d_denied;
   logic                                 d_corrupt;
   logic [DataWidth-1:0]                 d_data;

   modport master (
      output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_corrupt, a_data,
      input  a_ready,
      input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data,
      output d_ready
   );

   modport slave (
      input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_corrupt, a_data,
      output a_ready,
      output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data,
      input  d_ready
   );
endinterface

// File: rtl/tl_host_aggregator.sv
// N-host to 1-device TileLink-UH aggregator: source-ID shifting, host arbitration with
// burst locking, per-host outstanding limits and unbuffered D routing.
module tl_host_aggregator #(
   parameter int NumHosts          = 4,
   parameter int DataWidth         = 128,
   parameter int AddrWidth         = 56,
   parameter int HostSourceWidth   = 2,
   parameter int DeviceSourceWidth = 5,
   parameter int SinkWidth         = 1,
   parameter int MaxOutstanding    = 4,
   parameter bit RoundRobin        = 1'b1,
   localparam int CntWidth         = $clog2(MaxOutstanding + 1)
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   tl_host_aggregator_if.slave                host,
   tl_host_aggregator_if.master               device,
   output logic [NumHosts-1:0][CntWidth-1:0]  outstanding_o
);
   localparam int IdxW     = (NumHosts > 1) ? $clog2(NumHosts) : 1;
   localparam int LogBytes = $clog2(DataWidth / 8);
   localparam logic [2:0] OpPutFull    = 3'd0;
   localparam logic [2:0] OpPutPartial = 3'd1;
   localparam logic [2:0] OpAckData    = 3'd1;

   generate
      if (DeviceSourceWidth < HostSourceWidth + $clog2(NumHosts)) begin : g_bad_cfg
         $fatal(1, "DeviceSourceWidth too narrow for NumHosts host links");
      end
   endgenerate

   function automatic logic [7:0] beats_m1(input logic [2:0] size);
      if (int'(size) > LogBytes) begin
         return 8'((1 << (int'(size) - LogBytes)) - 1);
      end
      return 8'd0;
   endfunction

   logic [CntWidth-1:0]  r_outstanding [NumHosts];
   logic                 r_lock;
   logic [IdxW-1:0]      r_lock_idx;
   logic [IdxW-1:0]      r_rr_ptr;
   logic [7:0]           r_a_beat;
   logic [7:0]           r_d_beat;

   logic [NumHosts-1:0]  w_elig;
   logic [NumHosts-1:0]  w_inc;
   logic [NumHosts-1:0]  w_dec;
   logic [NumHosts-1:0]  w_d_sel;
   logic [IdxW-1:0]      w_win;
   logic [IdxW-1:0]      w_start;
   logic [IdxW-1:0]      w_next_ptr;
   logic                 w_found;
   logic                 w_a_fire;
   logic                 w_a_last;
   logic [7:0]           w_a_beats_m1;
   logic [2:0]           w_a_opcode;
   logic [AddrWidth-1:0] w_a_address;
   logic [DeviceSourceWidth-1:0] w_d_host;
   logic                 w_d_legal;
   logic                 w_d_fire;
   logic                 w_d_last;
   logic [7:0]           w_d_beats_m1;
   logic [SinkWidth-1:0] w_d_sink;

   assign w_start = RoundRobin ? r_rr_ptr : '0;

   // A locked burst owns the link; otherwise scan eligible hosts from the start pointer.
   always_comb begin
      int idx;
      idx     = 0;
      w_win   = '0;
      w_found = 1'b0;
      if (r_lock) begin
         w_win   = r_lock_idx;
         w_found = host.a_valid[r_lock_idx];
      end else begin
         for (int k = 0; k < NumHosts; k++) begin
            idx = (int'(w_start) + k) % NumHosts;
            if (!w_found && w_elig[idx]) begin
               w_win   = IdxW'(idx);
               w_found = 1'b1;
            end
         end
      end
   end

   assign w_a_opcode   = host.a_opcode[w_win];
   assign w_a_address  = host.a_address[w_win];
   assign w_a_beats_m1 = (w_a_opcode == OpPutFull || w_a_opcode == OpPutPartial) ?
                         beats_m1(host.a_size[w_win]) : 8'd0;
   assign w_a_last     = (r_a_beat == w_a_beats_m1);
   assign w_a_fire     = !rst_i && w_found && device.a_ready[0];
   assign w_next_ptr   = (int'(w_win) == NumHosts - 1) ? '0 : w_win + IdxW'(1);

   assign device.a_valid[0]   = !rst_i && w_found;
   assign device.a_opcode[0]  = w_a_opcode;
   assign device.a_param[0]   = host.a_param[w_win];
   assign device.a_size[0]    = host.a_size[w_win];
   assign device.a_source[0]  = (DeviceSourceWidth'(w_win) << HostSourceWidth) |
                                DeviceSourceWidth'(host.a_source[w_win]);
   assign device.a_address[0] = w_a_address;
   assign device.a_mask[0]    = host.a_mask[w_win];
   assign device.a_corrupt[0] = host.a_corrupt[w_win];
   assign device.a_data[0]    = host.a_data[w_win];

   assign w_d_host     = device.d_source >> HostSourceWidth;
   assign w_d_legal    = |w_d_sel;
   assign w_d_beats_m1 = (device.d_opcode == OpAckData) ? beats_m1(device.d_size) : 8'd0;
   assign w_d_last     = (r_d_beat == w_d_beats_m1);
   // Beats for a non-existent host are swallowed so the device never wedges.
   assign device.d_ready[0] = !rst_i && (w_d_legal ? |(host.d_ready & w_d_sel) : 1'b1);
   assign w_d_fire     = device.d_valid[0] && device.d_ready[0];
   assign w_d_sink     = device.d_sink;

   assign host.d_opcode  = device.d_opcode;
   assign host.d_param   = device.d_param;
   assign host.d_size    = device.d_size;
   assign host.d_source  = device.d_source[HostSourceWidth-1:0];
   assign host.d_sink    = w_d_sink;
   assign host.d_denied  = device.d_denied;
   assign host.d_corrupt = device.d_corrupt;
   assign host.d_data    = device.d_data;

   genvar gi;
   generate
      for (gi = 0; gi < NumHosts; gi++) begin : g_host
         assign w_elig[gi]  = host.a_valid[gi] && (r_outstanding[gi] < CntWidth'(MaxOutstanding));
         assign w_inc[gi]   = w_a_fire && !r_lock && (w_win == IdxW'(gi));
         assign w_d_sel[gi] = (w_d_host == DeviceSourceWidth'(gi));
         assign w_dec[gi]   = w_d_fire && w_d_sel[gi] && w_d_last;
         assign host.a_ready[gi] = w_a_fire && (w_win == IdxW'(gi));
         assign host.d_valid[gi] = !rst_i && device.d_valid[0] && w_d_sel[gi];
         assign outstanding_o[gi] = r_outstanding[gi];

         a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
            !(w_inc[gi] && !w_dec[gi] && r_outstanding[gi] == CntWidth'(MaxOutstanding)));
         a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
            !(w_dec[gi] && !w_inc[gi] && r_outstanding[gi] == '0));
      end
   endgenerate

   a_legal_d_host: assert property (@(posedge clk_i) disable iff (rst_i)
      !(device.d_valid[0] && !w_d_legal));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NumHosts; i++) r_outstanding[i] <= '0;
         r_lock     <= 1'b0;
         r_lock_idx <= '0;
         r_rr_ptr   <= '0;
         r_a_beat   <= '0;
         r_d_beat   <= '0;
      end else begin
         for (int i = 0; i < NumHosts; i++) begin
            if (w_inc[i] && !w_dec[i]) begin
               r_outstanding[i] <= r_outstanding[i] + CntWidth'(1);
            end else if (!w_inc[i] && w_dec[i]) begin
               r_outstanding[i] <= r_outstanding[i] - CntWidth'(1);
            end
         end
         if (w_a_fire) begin
            if (w_a_last) begin
               r_a_beat <= '0;
               r_lock   <= 1'b0;
               if (RoundRobin) r_rr_ptr <= w_next_ptr;
            end else begin
               r_a_beat   <= r_a_beat + 8'd1;
               r_lock     <= 1'b1;
               r_lock_idx <= w_win;
            end
         end
         if (w_d_fire) begin
            r_d_beat <= w_d_last ? 8'd0 : r_d_beat + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_tl_host_aggregator.sv
// Directed bench for tl_host_aggregator: a 4-host RR instance with limit 4 and a second
// instance with limit 2 for the stall case.
module tb_tl_host_aggregator;
   localparam logic [2:0] GET = 3'd4, PUTF = 3'd0, ACK = 3'd0, ACKD = 3'd1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   logic [3:0][2:0] outs_a;
   logic [3:0][1:0] outs_b;

   tl_host_aggregator_if #(.NumLanes(4), .SourceWidth(2)) hif ();
   tl_host_aggregator_if #(.NumLanes(1), .SourceWidth(5)) dif ();
   tl_host_aggregator_if #(.NumLanes(4), .SourceWidth(2)) hif2 ();
   tl_host_aggregator_if #(.NumLanes(1), .SourceWidth(5)) dif2 ();

   tl_host_aggregator #(.NumHosts(4), .DataWidth(128), .AddrWidth(56), .HostSourceWidth(2),
      .DeviceSourceWidth(5), .SinkWidth(1), .MaxOutstanding(4), .RoundRobin(1'b1))
   u_dut_a (.clk_i(clk), .rst_i(rst), .host(hif), .device(dif), .outstanding_o(outs_a));

   tl_host_aggregator #(.NumHosts(4), .DataWidth(128), .AddrWidth(56), .HostSourceWidth(2),
      .DeviceSourceWidth(5), .SinkWidth(1), .MaxOutstanding(2), .RoundRobin(1'b1))
   u_dut_b (.clk_i(clk), .rst_i(rst), .host(hif2), .device(dif2), .outstanding_o(outs_b));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s = 0x%0h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_a(input int h, input logic v, input logic [2:0] op,
                        input logic [2:0] sz, input logic [1:0] src);
      hif.a_valid[h]  = v;
      hif.a_opcode[h] = op;
      hif.a_size[h]   = sz;
      hif.a_source[h] = src;
   endtask

   task automatic set_d(input logic v, input logic [2:0] op, input logic [2:0] sz,
                        input logic [4:0] src);
      dif.d_valid[0] = v;
      dif.d_opcode   = op;
      dif.d_size     = sz;
      dif.d_source   = src;
   endtask

   task automatic ack(input logic [4:0] src);
      set_d(1'b1, ACK, 3'd3, src);
      #1;
      chk("ack dvalid", 64'(hif.d_valid), 64'(4'b1 << src[4:2]));
      step();
      set_d(1'b0, ACK, 3'd3, 5'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [4:0] srcs [5];
      srcs[0] = 5'h00; srcs[1] = 5'h00; srcs[2] = 5'h04; srcs[3] = 5'h08; srcs[4] = 5'h0C;
      for (int h = 0; h < 4; h++) begin
         hif.a_param[h] = 3'd0; hif.a_address[h] = 56'h1000 * h; hif.a_mask[h] = '1;
         hif.a_corrupt[h] = 1'b0; hif.a_data[h] = 128'(h);
         set_a(h, 1'b1, GET, 3'd3, 2'd0);
         hif2.a_param[h] = 3'd0; hif2.a_address[h] = '0; hif2.a_mask[h] = '1;
         hif2.a_corrupt[h] = 1'b0; hif2.a_data[h] = '0;
         hif2.a_valid[h] = 1'b0; hif2.a_opcode[h] = GET; hif2.a_size[h] = 3'd3;
         hif2.a_source[h] = 2'd0;
      end
      hif.d_ready = 4'hF; hif2.d_ready = 4'hF;
      dif.a_ready = 1'b1; dif2.a_ready = 1'b1;
      dif.d_param = '0; dif.d_sink = '0; dif.d_denied = 1'b0; dif.d_corrupt = 1'b0;
      dif.d_data = '0;
      dif2.d_param = '0; dif2.d_sink = '0; dif2.d_denied = 1'b0; dif2.d_corrupt = 1'b0;
      dif2.d_data = '0; dif2.d_valid = 1'b0; dif2.d_opcode = ACK; dif2.d_size = 3'd3;
      dif2.d_source = '0;
      set_d(1'b1, ACK, 3'd3, 5'h00);

      // reset state with live inputs
      #2;
      chk("rst dev_a_valid", 64'(dif.a_valid), 64'd0);
      chk("rst host_a_ready", 64'(hif.a_ready), 64'd0);
      chk("rst host_d_valid", 64'(hif.d_valid), 64'd0);
      chk("rst dev_d_ready", 64'(dif.d_ready), 64'd0);
      chk("rst outstanding", 64'(outs_a), 64'd0);
      set_d(1'b0, ACK, 3'd3, 5'h00);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // 1: round-robin over four simultaneous Gets
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("t1 grant%0d", k), 64'(hif.a_ready), 64'(1 << (k % 4)));
         chk($sformatf("t1 src%0d", k), 64'(dif.a_source[0]), 64'((k % 4) << 2));
         step();
      end
      hif.a_valid = 4'h0;
      #1;
      chk("t1 outs0", 64'(outs_a[0]), 64'd2);
      chk("t1 outs3", 64'(outs_a[3]), 64'd1);
      for (int k = 0; k < 5; k++) ack(srcs[k]);
      #1;
      chk("t1 drained", 64'(outs_a), 64'd0);

      // 3: limit 2 on the second instance
      hif2.a_valid[2] = 1'b1;
      #1; chk("t3 get0", 64'(hif2.a_ready), 64'h4); step();
      #1; chk("t3 get1", 64'(hif2.a_ready), 64'h4); step();
      #1; chk("t3 stall", 64'(hif2.a_ready), 64'h0);
      chk("t3 outs2", 64'(outs_b[2]), 64'd2);
      step();
      dif2.d_valid = 1'b1; dif2.d_source = 5'h08;
      #1; chk("t3 d_valid", 64'(hif2.d_valid), 64'h4);
      chk("t3 still stall", 64'(hif2.a_ready), 64'h0);
      step();
      dif2.d_valid = 1'b0;
      #1; chk("t3 outs after D", 64'(outs_b[2]), 64'd1);
      chk("t3 third get", 64'(hif2.a_ready), 64'h4);
      step();
      hif2.a_valid = 4'h0;
      #1; chk("t3 outs final", 64'(outs_b[2]), 64'd2);

      // 2: Put burst from host1 holds the grant against host0 (pointer at 3)
      set_a(2, 1'b1, GET, 3'd3, 2'd0);
      #1; chk("t2 pre get h2", 64'(hif.a_ready), 64'h4); step();
      set_a(2, 1'b0, GET, 3'd3, 2'd0);
      set_a(1, 1'b1, PUTF, 3'd6, 2'd0);
      #1; chk("t2 beat1", 64'(hif.a_ready), 64'h2); step();
      set_a(0, 1'b1, GET, 3'd3, 2'd0);
      for (int b = 2; b <= 4; b++) begin
         if (b == 3) begin
            dif.a_ready = 1'b0;
            #1;
            chk("t2 stall valid", 64'(dif.a_valid), 64'd1);
            chk("t2 stall ready", 64'(hif.a_ready), 64'h0);
            step();
            dif.a_ready = 1'b1;
         end
         #1;
         chk($sformatf("t2 beat%0d", b), 64'(hif.a_ready), 64'h2);
         chk($sformatf("t2 src%0d", b), 64'(dif.a_source[0]), 64'h04);
         step();
      end
      set_a(1, 1'b0, PUTF, 3'd6, 2'd0);
      #1; chk("t2 host0 after", 64'(hif.a_ready), 64'h1); step();
      set_a(0, 1'b0, GET, 3'd3, 2'd0);
      #1; chk("t2 outs1", 64'(outs_a[1]), 64'd1);
      ack(5'h08); ack(5'h04); ack(5'h00);
      #1; chk("t2 drained", 64'(outs_a), 64'd0);

      // 4: four-beat AccessAckData to host3
      set_a(3, 1'b1, GET, 3'd6, 2'd1);
      #1; chk("t4 get src", 64'(dif.a_source[0]), 64'h0D); step();
      set_a(3, 1'b0, GET, 3'd6, 2'd1);
      set_d(1'b1, ACKD, 3'd6, 5'h0D);
      for (int b = 0; b < 4; b++) begin
         if (b == 1) begin
            hif.d_ready = 4'h0;
            #1; chk("t4 backpressure", 64'(dif.d_ready), 64'd0); step();
            hif.d_ready = 4'hF;
         end
         #1;
         chk($sformatf("t4 dvalid%0d", b), 64'(hif.d_valid), 64'h8);
         chk($sformatf("t4 dsrc%0d", b), 64'(hif.d_source), 64'd1);
         chk($sformatf("t4 outs%0d", b), 64'(outs_a[3]), 64'd1);
         step();
      end
      set_d(1'b0, ACK, 3'd3, 5'h00);
      #1; chk("t4 outs after last", 64'(outs_a[3]), 64'd0);

      // 5: same-cycle first A beat and last D beat for host0
      set_a(0, 1'b1, GET, 3'd3, 2'd0);
      #1; chk("t5 get", 64'(hif.a_ready), 64'h1); step();
      #1; chk("t5 outs1", 64'(outs_a[0]), 64'd1);
      set_d(1'b1, ACK, 3'd3, 5'h00);
      #1; chk("t5 both", 64'({hif.a_ready, hif.d_valid}), 64'h11); step();
      set_a(0, 1'b0, GET, 3'd3, 2'd0);
      set_d(1'b0, ACK, 3'd3, 5'h00);
      #1; chk("t5 outs held", 64'(outs_a[0]), 64'd1);
      ack(5'h00);

      // 6: reset in the middle of a Put burst
      set_a(1, 1'b1, PUTF, 3'd6, 2'd0);
      #1; chk("t6 beat1", 64'(hif.a_ready), 64'h2); step();
      #1; chk("t6 beat2", 64'(hif.a_ready), 64'h2); step();
      set_d(1'b1, ACK, 3'd3, 5'h04);
      #1; rst = 1'b1;
      #1;
      chk("t6 dev_a_valid", 64'(dif.a_valid), 64'd0);
      chk("t6 host_a_ready", 64'(hif.a_ready), 64'd0);
      chk("t6 host_d_valid", 64'(hif.d_valid), 64'd0);
      chk("t6 dev_d_ready", 64'(dif.d_ready), 64'd0);
      chk("t6 outs cleared", 64'(outs_a), 64'd0);
      set_d(1'b0, ACK, 3'd3, 5'h00);
      set_a(1, 1'b0, PUTF, 3'd6, 2'd0);
      step();
      rst = 1'b0;
      for (int h = 0; h < 4; h++) set_a(h, 1'b1, GET, 3'd3, 2'd0);
      #1;
      chk("t6 rr ptr zero", 64'(hif.a_ready), 64'h1);
      chk("t6 outs zero", 64'(outs_a), 64'd0);
      hif.a_valid = 4'h0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
